// File: rtl/game_ctrl.sv
// Game sequencer: IDLE -> SERVE -> PLAY -> WIN/LOSE -> IDLE, tracking lives and
// a saturating block-hit score. Frame-based timers pace SERVE and the end screens.
module game_ctrl #(
  parameter int LIVES_INIT   = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int END_FRAMES   = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       frame_tick,
  input  logic       ball_lost,
  input  logic [9:0] collide_block,
  input  logic [9:0] alive_mask,
  output logic       run_en,
  output logic       serve,
  output logic       blocks_reset,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_t;

  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
  localparam logic [7:0] END_LOAD   = 8'(END_FRAMES);
  localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] score_q, score_d;
  logic       blocks_reset_q, blocks_reset_d;
  logic [3:0] hits;
  logic [8:0] score_sum;

  always_comb begin
    hits = '0;
    for (int i = 0; i < 10; i++) begin
      hits = hits + 4'(collide_block[i]);
    end
    score_sum = {1'b0, score_q} + {5'b0, hits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      lives_q        <= '0;
      score_q        <= '0;
      blocks_reset_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lives_q        <= lives_d;
      score_q        <= score_d;
      blocks_reset_q <= blocks_reset_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lives_d        = lives_q;
    score_d        = score_q;
    blocks_reset_d = 1'b0;
    run_en         = 1'b0;
    serve          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_SERVE;
          cnt_d          = SERVE_LOAD;
          lives_d        = LIVES_LOAD;
          score_d        = '0;
          blocks_reset_d = 1'b1;
        end
      end

      S_SERVE: begin
        serve = 1'b1;
        if (frame_tick) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            state_d = S_PLAY;
          end
        end
      end

      S_PLAY: begin
        run_en = ~pause;
        if (!pause) begin
          score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
          // Clearing the last block wins even if the ball drops in the same cycle.
          if (alive_mask == '0) begin
            state_d = S_WIN;
            cnt_d   = END_LOAD;
          end else if (ball_lost) begin
            if (lives_q <= 2'd1) begin
              lives_d = '0;
              state_d = S_LOSE;
              cnt_d   = END_LOAD;
            end else begin
              lives_d = lives_q - 2'd1;
              state_d = S_SERVE;
              cnt_d   = SERVE_LOAD;
            end
          end
        end
      end

      S_WIN, S_LOSE: begin
        if (frame_tick) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign blocks_reset = blocks_reset_q;
  assign lives        = lives_q;
  assign score        = score_q;
  assign state        = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios followed by random traffic, every cycle
// compared against a rule-level model of the game flow.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, pause, frame_tick, ball_lost;
  logic [9:0] collide_block, alive_mask;
  logic       run_en, serve, blocks_reset;
  logic [1:0] lives;
  logic [7:0] score;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: phase, frames remaining on the current timer, lives, score.
  int exp_phase, exp_frames, exp_lives, exp_score, exp_br;
  localparam int IDLE = 0, SERVE = 1, PLAY = 2, WIN = 3, LOSE = 4;

  game_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .frame_tick(frame_tick),
    .ball_lost(ball_lost), .collide_block(collide_block), .alive_mask(alive_mask),
    .run_en(run_en), .serve(serve), .blocks_reset(blocks_reset),
    .lives(lives), .score(score), .state(state)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    exp_br = 0;
    if (rst) begin
      exp_phase = IDLE; exp_frames = 0; exp_lives = 0; exp_score = 0;
    end else if (exp_phase == IDLE) begin
      if (start) begin
        exp_phase = SERVE; exp_frames = 60; exp_lives = 3; exp_score = 0; exp_br = 1;
      end
    end else if (exp_phase == PLAY) begin
      if (!pause) begin
        exp_score = exp_score + $countones(collide_block);
        if (exp_score > 255) exp_score = 255;
        if (alive_mask == 0) begin
          exp_phase = WIN; exp_frames = 120;
        end else if (ball_lost) begin
          exp_lives = exp_lives - 1;
          if (exp_lives <= 0) begin
            exp_lives = 0; exp_phase = LOSE; exp_frames = 120;
          end else begin
            exp_phase = SERVE; exp_frames = 60;
          end
        end
      end
    end else if (frame_tick) begin
      // SERVE, WIN and LOSE are all plain frame countdowns.
      exp_frames = exp_frames - 1;
      if (exp_frames == 0) exp_phase = (exp_phase == SERVE) ? PLAY : IDLE;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("state", 32'(state), 32'(exp_phase));
    chk("lives", 32'(lives), 32'(exp_lives));
    chk("score", 32'(score), 32'(exp_score));
    chk("blocks_reset", 32'(blocks_reset), 32'(exp_br));
    chk("serve", 32'(serve), 32'(exp_phase == SERVE));
    chk("run_en", 32'(run_en), 32'(exp_phase == PLAY && !pause));
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) cyc();
    frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  initial begin
    int saved_score;
    rst = 1'b1; start = 1'b0; pause = 1'b0; frame_tick = 1'b0; ball_lost = 1'b0;
    collide_block = '0; alive_mask = 10'h3FF;
    exp_phase = IDLE; exp_frames = 0; exp_lives = 0; exp_score = 0; exp_br = 0;
    cyc(); cyc();
    chk("reset_state", 32'(state), 0);
    chk("reset_lives", 32'(lives), 0);
    rst = 1'b0;
    cyc();

    // Game start and serve timing
    pulse_start();
    chk("start_state", 32'(state), 1);
    chk("start_lives", 32'(lives), 3);
    chk("start_br", 32'(blocks_reset), 1);
    cyc();
    chk("br_one_cycle", 32'(blocks_reset), 0);
    ticks(59);
    chk("serve_59", 32'(state), 1);
    ticks(1);
    chk("play_state", 32'(state), 2);
    chk("play_run_en", 32'(run_en), 1);

    // Scoring and saturation
    collide_block = 10'b0000000101; cyc();
    chk("score_plus2", 32'(score), 2);
    collide_block = 10'h3FF; repeat (25) cyc();
    collide_block = 10'b0000000011; cyc();
    chk("score_254", 32'(score), 254);
    collide_block = 10'b0000000111; cyc();
    chk("score_sat", 32'(score), 255);
    collide_block = 10'h001; cyc();
    chk("score_hold_255", 32'(score), 255);
    collide_block = '0;

    // Losing all lives
    ball_lost = 1'b1; cyc(); ball_lost = 1'b0;
    chk("lost1_lives", 32'(lives), 2);
    chk("lost1_state", 32'(state), 1);
    ticks(60);
    ball_lost = 1'b1; cyc(); ball_lost = 1'b0;
    chk("lost2_lives", 32'(lives), 1);
    ticks(60);
    ball_lost = 1'b1; cyc(); ball_lost = 1'b0;
    chk("lose_lives", 32'(lives), 0);
    chk("lose_state", 32'(state), 4);
    ticks(119);
    chk("lose_119", 32'(state), 4);
    ticks(1);
    chk("lose_to_idle", 32'(state), 0);

    // Win beats ball loss; start ignored in WIN
    pulse_start(); ticks(60);
    alive_mask = '0; ball_lost = 1'b1; cyc(); ball_lost = 1'b0; alive_mask = 10'h3FF;
    chk("win_state", 32'(state), 3);
    chk("win_lives", 32'(lives), 3);
    pulse_start();
    chk("win_start_ignored", 32'(state), 3);
    ticks(120);
    chk("win_to_idle", 32'(state), 0);

    // Pause freezes play
    pulse_start(); ticks(60);
    saved_score = int'(score);
    pause = 1'b1; ball_lost = 1'b1; collide_block = 10'h3FF; alive_mask = '0; cyc();
    ball_lost = 1'b0; collide_block = '0; alive_mask = 10'h3FF;
    chk("pause_run_en", 32'(run_en), 0);
    chk("pause_score", 32'(score), 32'(saved_score));
    chk("pause_state", 32'(state), 2);
    pause = 1'b0; cyc();
    chk("unpause_run_en", 32'(run_en), 1);

    // Reset mid-serve
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    pulse_start(); ticks(30);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_serve_state", 32'(state), 0);
    chk("rst_serve_serve", 32'(serve), 0);
    chk("rst_serve_br", 32'(blocks_reset), 0);
    chk("rst_serve_lives", 32'(lives), 0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      rst           = ($urandom_range(0, 499) == 0);
      start         = ($urandom_range(0, 19) == 0);
      pause         = ($urandom_range(0, 7) == 0);
      frame_tick    = ($urandom_range(0, 2) == 0);
      ball_lost     = ($urandom_range(0, 29) == 0);
      collide_block = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'd0;
      alive_mask    = ($urandom_range(0, 149) == 0) ? 10'd0 : (10'($urandom) | 10'd1);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
